// File: rtl/addr8s_pkg.sv
// Shared types and helpers for the adder-sum accumulator.
//   state_e          : accumulator FSM states
//   SUM_W            : width of the upstream adder sum (8b + 8b signed -> 9b)
//   sat_max/sat_min  : two's complement clamp values for a given width,
//                      returned in the low w bits of a 32-bit word
package addr8s_pkg;

    localparam int SUM_W = 9;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    function automatic logic [31:0] sat_max(input int unsigned w);
        return (32'd1 << (w - 32'd1)) - 32'd1;
    endfunction

    // Inverting max gives 1 followed by zeros in the low w bits.
    function automatic logic [31:0] sat_min(input int unsigned w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/addr8s_sat_add.sv
// Combinational saturating adder.
// Ports:
//   acc_i    in  ACC_W  running total, signed
//   sum_i    in  SUM_W  new sample, signed
//   result_o out ACC_W  clamp(acc_i + sum_i)
//   ovf_o    out 1      the clamp was applied
module addr8s_sat_add
    import addr8s_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int SUM_W = addr8s_pkg::SUM_W
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [SUM_W-1:0] sum_i,
    output logic [ACC_W-1:0] result_o,
    output logic             ovf_o
);

    localparam logic [ACC_W-1:0] MAX_V = ACC_W'(sat_max(ACC_W));
    localparam logic [ACC_W-1:0] MIN_V = ACC_W'(sat_min(ACC_W));

    logic [ACC_W:0] wide;

    always_comb begin
        // One guard bit is enough: |acc| + |sum| never exceeds 2^ACC_W.
        wide = {acc_i[ACC_W-1], acc_i}
             + {{(ACC_W + 1 - SUM_W){sum_i[SUM_W-1]}}, sum_i};
        // Guard and sign bit disagree -> result left the ACC_W range.
        ovf_o = wide[ACC_W] ^ wide[ACC_W-1];
        if (ovf_o) begin
            result_o = wide[ACC_W] ? MIN_V : MAX_V;
        end else begin
            result_o = wide[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/addr8s_sum_accumulator.sv
// Frame accumulator behind the 8-bit signed adder. Sums FRAME_LEN accepted
// samples with saturation, then holds the result on a valid/ready port.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   sum_i/sum_valid_i/sum_ready_o   sample input handshake
//   clear_i                  synchronous frame abort (beats everything)
//   acc_o/acc_valid_o/acc_ready_i   frame result handshake
//   sat_o                    frame clamped at least once
//   count_o                  samples accepted so far in this frame
module addr8s_sum_accumulator
    import addr8s_pkg::*;
#(
    parameter  int SUM_W     = addr8s_pkg::SUM_W,
    parameter  int ACC_W     = 16,
    parameter  int FRAME_LEN = 16,
    localparam int CNT_W     = $clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SUM_W-1:0] sum_i,
    input  logic             sum_valid_i,
    output logic             sum_ready_o,
    input  logic             clear_i,
    output logic [ACC_W-1:0] acc_o,
    output logic             acc_valid_o,
    input  logic             acc_ready_i,
    output logic             sat_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [ACC_W-1:0] add_res;
    logic             add_ovf;
    logic             accept;

    addr8s_sat_add #(
        .ACC_W (ACC_W),
        .SUM_W (SUM_W)
    ) u_sat_add (
        .acc_i    (acc_q),
        .sum_i    (sum_i),
        .result_o (add_res),
        .ovf_o    (add_ovf)
    );

    assign sum_ready_o = (state_q == ACCUM);
    assign acc_valid_o = (state_q == HOLD);
    assign acc_o       = acc_q;
    assign sat_o       = sat_q;
    assign count_o     = cnt_q;

    // clear_i drops a sample offered in the same cycle even though ready is high.
    assign accept = sum_valid_i & sum_ready_o & ~clear_i;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sat_d   = sat_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            state_d = ACCUM;
            acc_d   = '0;
            sat_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    // add_res is only consumed on accept, so X on an idle
                    // sum_i never reaches the registers.
                    if (accept) begin
                        acc_d = add_res;
                        sat_d = sat_q | add_ovf;
                        if (cnt_q == LAST_CNT) begin
                            cnt_d   = '0;
                            state_d = HOLD;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (acc_ready_i) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        sat_d   = 1'b0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
